sha_pad: RTL and testbench

SHA_PAD -- requirements
Module: sha_pad

---
 rtl/sha_pad_pkg.sv | 59 +++++
 rtl/sha_pad_if.sv | 38 +++
 rtl/sha_pad.sv | 156 +++++++++++++++
 tb/tb_sha_pad.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_pad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha_const (package)
// Purpose  : Shared constants, state encoding and register layout for the
//            SHA message padder (sha_pad) and its bus interface.
// Contents : ND  - bytes per compression block
//            NL  - bytes of big-endian bit length at the end of the last block
//            S_* - FSM state encoding
//            pad_reg_t - the single registered state struct of sha_pad
//            len_byte  - selects one byte of the big-endian bit length
// Config   : none (SHA_PAD_ABORT_EN is consumed by sha_pad only)
// Revision : 1.0 - initial release
// ============================================================================
package sha_const;

  localparam int ND = 64;
  localparam int NL = 8;
  localparam int CW = $clog2(ND);
  localparam int LW = $clog2(NL);

  localparam logic [CW-1:0] CNT_LAST  = CW'(ND - 1);
  localparam logic [CW-1:0] LEN_START = CW'(ND - NL);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_PAD   = 3'd2;
  localparam logic [2:0] S_LEN   = 3'd3;
  localparam logic [2:0] S_ISSUE = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;

  // Byte i of the block is element [i]; byte 0 is the first message byte.
  typedef logic [ND-1:0][7:0] block_t;

  typedef struct packed {
    logic [2:0]    state;
    logic [CW-1:0] cnt;    // next byte position in the block
    logic [63:0]   len;    // message length in bytes, wraps mod 2^64
    logic          first;  // current block is the first of the message
    logic          tail;   // 0x80 terminator already written
    logic          done;   // length field written, message complete
    logic          last;   // final input beat seen, only padding remains
    logic          enable;
    logic          func;
    block_t        blk;
  } pad_reg_t;

  // Length field occupies the last NL bytes. Because ND-NL is a multiple of
  // NL, the low LW bits of cnt directly index the length byte (0 = MSB).
  function automatic logic [7:0] len_byte(input logic [63:0] len,
                                          input logic [CW-1:0] cnt);
    logic [LW-1:0] k;
    logic [63:0]   v;
    k = cnt[LW-1:0];
    v = {len[60:0], 3'b000} >> {LW'(NL - 1) - k, 3'b000};
    return v[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha_pad_if.sv
`default_nettype none
// ============================================================================
// Module   : sha_pad_if (interface)
// Purpose  : Groups the byte-stream input and the block output of sha_pad.
// Signals  : In_Data[7:0], In_Valid, In_Keep, In_Last -> padder (stream in)
//            In_Ready                                 <- padder
//            Data_Block[ND][8], Enable, Function, Busy <- padder (to core)
//            Ready                                    -> padder (from core)
// Modports : slave  - the padder side
//            master - the producer/core side
// Revision : 1.0 - initial release
// ============================================================================
interface sha_pad_if;
  import sha_const::*;

  logic [7:0] In_Data;
  logic       In_Valid;
  logic       In_Keep;
  logic       In_Last;
  logic       In_Ready;
  block_t     Data_Block;
  logic       Enable;
  logic       Function;
  logic       Ready;
  logic       Busy;

  modport slave (
    input  In_Data, In_Valid, In_Keep, In_Last, Ready,
    output In_Ready, Data_Block, Enable, Function, Busy
  );

  modport master (
    output In_Data, In_Valid, In_Keep, In_Last, Ready,
    input  In_Ready, Data_Block, Enable, Function, Busy
  );

endinterface
`default_nettype wire

// File: rtl/sha_pad.sv
`default_nettype none
// ============================================================================
// Module   : sha_pad
// Purpose  : Message padder for a SHA-style hash core. Collects message
//            bytes into ND-byte blocks, appends 0x80, zero fill and the
//            NL-byte big-endian bit length, and hands each block to the core
//            with a one-cycle Enable pulse, waiting for Ready between blocks.
// Ports    : clk   - clock, rising edge
//            rst   - asynchronous active-low reset
//            Abort - (SHA_PAD_ABORT_EN only) drop the current message
//            bus   - sha_pad_if.slave (stream in, block out, core handshake)
// Config   : `define SHA_PAD_ABORT_EN adds the Abort input.
// Revision : 1.0 - initial release
// ============================================================================
module sha_pad
  import sha_const::*;
(
  input  logic        clk,
  input  logic        rst,
`ifdef SHA_PAD_ABORT_EN
  input  logic        Abort,
`endif
  sha_pad_if.slave    bus
);

  pad_reg_t pad_q;
  pad_reg_t pad_d;
  logic     abort_w;
  logic     in_rdy_w;
  logic     accept_w;

`ifdef SHA_PAD_ABORT_EN
  assign abort_w = Abort;
`else
  assign abort_w = 1'b0;
`endif

  // Abort wins over a simultaneous beat, so it also withholds In_Ready.
  assign in_rdy_w = ((pad_q.state == S_IDLE) || (pad_q.state == S_FILL)) && !abort_w;
  assign accept_w = bus.In_Valid && in_rdy_w;

  always_comb begin
    pad_d        = pad_q;
    pad_d.enable = 1'b0;

    case (pad_q.state)
      S_IDLE, S_FILL: begin
        if (accept_w) begin
          if (bus.In_Keep) begin
            pad_d.blk[pad_q.cnt] = bus.In_Data;
            pad_d.cnt            = pad_q.cnt + CW'(1);
            pad_d.len            = pad_q.len + 64'd1;
            pad_d.state          = S_FILL;
            if (pad_q.state == S_IDLE) pad_d.first = 1'b1;
            if (bus.In_Last) begin
              pad_d.last  = 1'b1;
              // A byte landing in the final slot fills the block; padding
              // resumes in a fresh block after the core takes this one.
              pad_d.state = (pad_q.cnt == CNT_LAST) ? S_ISSUE : S_PAD;
            end else if (pad_q.cnt == CNT_LAST) begin
              pad_d.state = S_ISSUE;
            end
          end else if (bus.In_Last) begin
            // Empty terminating beat: nothing to store, start padding.
            if (pad_q.state == S_IDLE) pad_d.first = 1'b1;
            pad_d.last  = 1'b1;
            pad_d.state = S_PAD;
          end
          // Keep=0 without Last is discarded.
        end
      end

      S_PAD: begin
        pad_d.blk[pad_q.cnt] = pad_q.tail ? 8'h00 : 8'h80;
        pad_d.tail           = 1'b1;
        pad_d.cnt            = pad_q.cnt + CW'(1);
        if (pad_q.cnt == CNT_LAST) begin
          pad_d.state = S_ISSUE;          // no room for length: extra block
        end else if (pad_d.cnt == LEN_START) begin
          pad_d.state = S_LEN;            // tail is always set by this write
        end
      end

      S_LEN: begin
        pad_d.blk[pad_q.cnt] = len_byte(pad_q.len, pad_q.cnt);
        pad_d.cnt            = pad_q.cnt + CW'(1);
        if (pad_q.cnt == CNT_LAST) begin
          pad_d.done  = 1'b1;
          pad_d.state = S_ISSUE;
        end
      end

      S_ISSUE: begin
        pad_d.state = S_WAIT;
      end

      S_WAIT: begin
        if (bus.Ready) begin
          pad_d.cnt   = '0;
          pad_d.first = 1'b0;
          if (pad_q.done) begin
            pad_d.state = S_IDLE;
            pad_d.len   = '0;
            pad_d.done  = 1'b0;
            pad_d.tail  = 1'b0;
            pad_d.last  = 1'b0;
          end else if (pad_q.last) begin
            pad_d.state = S_PAD;
          end else begin
            pad_d.state = S_FILL;
          end
        end
      end

      default: begin
        pad_d.state = S_IDLE;
      end
    endcase

    // Enable and Function are registered so the pulse coincides with the
    // ISSUE cycle and Data_Block is already final.
    if ((pad_d.state == S_ISSUE) && (pad_q.state != S_ISSUE)) begin
      pad_d.enable = 1'b1;
      pad_d.func   = ~pad_d.first;
    end

    if (abort_w) begin
      pad_d.state  = S_IDLE;
      pad_d.cnt    = '0;
      pad_d.len    = '0;
      pad_d.first  = 1'b0;
      pad_d.tail   = 1'b0;
      pad_d.done   = 1'b0;
      pad_d.last   = 1'b0;
      pad_d.enable = 1'b0;
      pad_d.func   = pad_q.func;
      pad_d.blk    = pad_q.blk;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pad_q <= '0;
    end else begin
      pad_q <= pad_d;
    end
  end

  assign bus.In_Ready   = in_rdy_w;
  assign bus.Data_Block = pad_q.blk;
  assign bus.Enable     = pad_q.enable;
  assign bus.Function   = pad_q.func;
  assign bus.Busy       = (pad_q.state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sha_pad.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha_pad
// Purpose  : Self-checking bench for sha_pad. Messages are padded by a
//            byte-queue reference model into expected blocks; a monitor
//            compares every Enable against the expected queue and checks
//            that the block is held while the core stalls.
// Config   : honours SHA_PAD_ABORT_EN (adds the Abort scenario).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sha_pad;
  import sha_const::*;

  typedef logic [7:0] bq_t [$];
  typedef struct {
    block_t blk;
    logic   fn;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sha_pad_if bus();

`ifdef SHA_PAD_ABORT_EN
  logic Abort = 1'b0;
`endif

  sha_pad dut (
    .clk   (clk),
    .rst   (rst),
`ifdef SHA_PAD_ABORT_EN
    .Abort (Abort),
`endif
    .bus   (bus)
  );

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  bit   hold = 1'b0;
  int   n_en = 0;
  int   stall_cnt = 0;
  bit   ready_always = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference padding: msg || 0x80 || 0x00.. || bitlen (64-bit big-endian),
  // split into ND-byte blocks; only the first block is a fresh start.
  task automatic push_expected(input bq_t msg);
    bq_t             p;
    longint unsigned bits;
    exp_t            e;
    p = msg;
    p.push_back(8'h80);
    while ((p.size() % ND) != (ND - NL)) p.push_back(8'h00);
    bits = longint'(msg.size()) * 8;
    for (int i = NL - 1; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
    for (int b = 0; b < p.size() / ND; b++) begin
      for (int j = 0; j < ND; j++) e.blk[j] = p[b * ND + j];
      e.fn = (b != 0);
      expq.push_back(e);
    end
  endtask

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    block_t held;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold = 1'b0;
        continue;
      end
      if (bus.Enable === 1'b1) begin
        chk("enable_while_waiting", 512'(hold), 512'(0));
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_enable actual=1 required=0");
        end else begin
          e = expq.pop_front();
          chk("block", bus.Data_Block, e.blk);
          chk("function", 512'(bus.Function), 512'(e.fn));
        end
        held = bus.Data_Block;
        hold = 1'b1;
        n_en++;
        if ((n_en % 4) == 2) stall_cnt = 20;
      end else if (hold) begin
        chk("hold_block", bus.Data_Block, held);
        chk("hold_in_ready", 512'(bus.In_Ready), 512'(0));
        chk("hold_busy", 512'(bus.Busy), 512'(1));
        if (bus.Ready) hold = 1'b0;
      end
    end
  end

  // Core-side Ready driver, changes just after the rising edge.
  initial begin
    bus.Ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_cnt > 0) begin
        bus.Ready = 1'b0;
        stall_cnt--;
      end else if (ready_always) begin
        bus.Ready = 1'b1;
      end else begin
        bus.Ready = ($urandom_range(0, 2) != 0);
      end
    end
  end

  task automatic drive_beat(input logic [7:0] d, input bit k, input bit l);
    int t;
    bit ok;
    t = 0;
    bus.In_Data  = d;
    bus.In_Keep  = k;
    bus.In_Last  = l;
    bus.In_Valid = 1'b1;
    do begin
      @(negedge clk);
      ok = bus.In_Ready;
      t++;
    end while (!ok && t < 1000);
    if (!ok) chk("in_ready_timeout", 512'(ok), 512'(1));
    @(posedge clk);
    #1;
    bus.In_Valid = 1'b0;
  endtask

  task automatic send(input bq_t msg, input bit finish, input bit empty_tail, input bit bubbles);
    int nb;
    if (finish) push_expected(msg);
    nb = msg.size() + ((finish && (empty_tail || msg.size() == 0)) ? 1 : 0);
    for (int i = 0; i < nb; i++) begin
      if (bubbles && $urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      if (bubbles && $urandom_range(0, 6) == 0) drive_beat(8'($urandom), 1'b0, 1'b0);
      if (i < msg.size()) drive_beat(msg[i], 1'b1, finish && (i == nb - 1));
      else drive_beat(8'($urandom), 1'b0, 1'b1);
    end
  endtask

  task automatic wait_idle();
    int t;
    bit ok;
    t  = 0;
    ok = 1'b0;
    while (!ok && t < 5000) begin
      @(negedge clk);
      ok = (expq.size() == 0) && !hold && (bus.Busy == 1'b0);
      t++;
    end
    chk("drain", 512'(ok), 512'(1));
    @(posedge clk);
    #1;
  endtask

  function automatic bq_t mk(input int n, input bit rnd);
    bq_t m;
    for (int i = 0; i < n; i++) m.push_back(rnd ? 8'($urandom) : 8'h00);
    return m;
  endfunction

  initial begin
    bq_t    abc;
    bq_t    m;
    int     n;
    block_t snap;
    abc = '{8'h61, 8'h62, 8'h63};
    bus.In_Valid = 1'b0;
    bus.In_Data  = 8'h00;
    bus.In_Keep  = 1'b0;
    bus.In_Last  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 512'(bus.Busy), 512'(0));
    chk("rst_enable", 512'(bus.Enable), 512'(0));
    chk("rst_function", 512'(bus.Function), 512'(0));
    chk("rst_block", bus.Data_Block, 512'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 512'(bus.In_Ready), 512'(1));
    @(posedge clk);
    #1;

    // Directed boundary messages with the core always ready.
    ready_always = 1'b1;
    send(abc, 1'b1, 1'b0, 1'b0);
    send(mk(0, 1'b0), 1'b1, 1'b0, 1'b0);
    send(mk(55, 1'b0), 1'b1, 1'b0, 1'b0);
    send(mk(56, 1'b0), 1'b1, 1'b0, 1'b0);
    send(mk(64, 1'b0), 1'b1, 1'b0, 1'b0);
    wait_idle();
    ready_always = 1'b0;

    // Reset in the middle of a message, then "abc".
    send(mk(10, 1'b1), 1'b0, 1'b0, 1'b0);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_busy", 512'(bus.Busy), 512'(0));
    chk("mid_rst_block", bus.Data_Block, 512'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    send(abc, 1'b1, 1'b0, 1'b0);
    wait_idle();

`ifdef SHA_PAD_ABORT_EN
    send(mk(10, 1'b1), 1'b0, 1'b0, 1'b0);
    snap         = bus.Data_Block;
    Abort        = 1'b1;
    bus.In_Data  = 8'h55;
    bus.In_Keep  = 1'b1;
    bus.In_Last  = 1'b0;
    bus.In_Valid = 1'b1;
    #1;
    chk("abort_in_ready", 512'(bus.In_Ready), 512'(0));
    @(posedge clk);
    #1;
    Abort        = 1'b0;
    bus.In_Valid = 1'b0;
    chk("abort_busy", 512'(bus.Busy), 512'(0));
    chk("abort_block_kept", bus.Data_Block, snap);
    send(abc, 1'b1, 1'b0, 1'b0);
    wait_idle();
`endif

    // Randomised messages, random Ready, bubbles and empty tails.
    for (int k = 0; k < 25; k++) begin
      case ($urandom_range(0, 3))
        0:       n = 55 + $urandom_range(0, 9);
        1:       n = 119 + $urandom_range(0, 9);
        default: n = $urandom_range(0, 140);
      endcase
      m = mk(n, 1'b1);
      send(m, 1'b1, ($urandom_range(0, 2) == 0), 1'b1);
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
